// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_v2 family.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        PUSH_ONLY = 2'b00,
        POP_ONLY  = 2'b01,
        BOTH      = 2'b10,
        IDLE      = 2'b11
    } fifo_op_e;

    function automatic int unsigned level_width(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_v2_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_v2_ram #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock valid/ready FIFO with fill level, threshold flags, flush, sticky
// error flags and an optional registered output stage.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned OUT_REG       = 0,
    parameter int unsigned CAP           = DEPTH + OUT_REG,
    parameter int unsigned AFULL_THRESH  = CAP - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned LEVEL_WIDTH   = level_width(CAP)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push_valid,
    input  logic [WIDTH-1:0]       i_push_data,
    output logic                   o_push_ready,
    output logic                   o_pop_valid,
    output logic [WIDTH-1:0]       o_pop_data,
    input  logic                   i_pop_ready,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_almost_full,
    output logic                   o_almost_empty,
    output logic [LEVEL_WIDTH-1:0] o_level,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEVEL_WIDTH-1:0] CAP_L    = LEVEL_WIDTH'(CAP);
    localparam logic [LEVEL_WIDTH-1:0] AFULL_L  = LEVEL_WIDTH'(AFULL_THRESH);
    localparam logic [LEVEL_WIDTH-1:0] AEMPTY_L = LEVEL_WIDTH'(AEMPTY_THRESH);
    localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(DEPTH - 1);

    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic                   overflow_q, underflow_q;
    logic                   push_fire, pop_fire;
    logic                   ram_we, ram_re;
    logic [WIDTH-1:0]       ram_rdata;
    fifo_op_e               op;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_push_ready   = (level_q != CAP_L);
    assign o_pop_valid    = (level_q != '0);
    assign o_full         = (level_q == CAP_L);
    assign o_empty        = (level_q == '0);
    assign o_almost_full  = (level_q >= AFULL_L);
    assign o_almost_empty = (level_q <= AEMPTY_L);
    assign o_level        = level_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

    assign push_fire = i_push_valid && o_push_ready && !i_flush;
    assign pop_fire  = i_pop_ready && o_pop_valid && !i_flush;

    always_comb begin
        op = IDLE;
        if (push_fire && pop_fire) begin
            op = BOTH;
        end else if (push_fire) begin
            op = PUSH_ONLY;
        end else if (pop_fire) begin
            op = POP_ONLY;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case (op)
            PUSH_ONLY: level_d = level_q + LEVEL_WIDTH'(1);
            POP_ONLY:  level_d = level_q - LEVEL_WIDTH'(1);
            default:   level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (i_flush) begin
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (ram_we) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (ram_re) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (i_push_valid && !o_push_ready) begin
                overflow_q <= 1'b1;
            end
            if (i_pop_ready && !o_pop_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

    sync_fifo_v2_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_push_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (ram_rdata)
    );

    if (OUT_REG == 0) begin : g_comb_out
        assign ram_we     = push_fire;
        assign ram_re     = pop_fire;
        assign o_pop_data = ram_rdata;
    end else begin : g_reg_out
        logic             stage_valid_q;
        logic [WIDTH-1:0] stage_data_q;
        logic             ram_has_data;
        logic             stage_load;

        // Level counts the stage word too, so RAM holds data iff level exceeds the stage bit.
        assign ram_has_data = (level_q != {{(LEVEL_WIDTH-1){1'b0}}, stage_valid_q});
        assign stage_load   = !stage_valid_q || pop_fire;
        assign ram_re       = stage_load && ram_has_data && !i_flush;
        // A bypassed push goes straight into the stage and skips the RAM.
        assign ram_we       = push_fire && !(stage_load && !ram_has_data);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                stage_valid_q <= 1'b0;
                stage_data_q  <= '0;
            end else if (i_flush) begin
                stage_valid_q <= 1'b0;
            end else if (stage_load) begin
                if (ram_has_data) begin
                    stage_valid_q <= 1'b1;
                    stage_data_q  <= ram_rdata;
                end else if (push_fire) begin
                    stage_valid_q <= 1'b1;
                    stage_data_q  <= i_push_data;
                end else begin
                    stage_valid_q <= 1'b0;
                end
            end
        end

        assign o_pop_data = stage_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Drives a combinational-output and a registered-output FIFO (both capacity 5) with the
// same directed stimulus and checks both against a queue model and literal expectations.
module tb_sync_fifo_v2;

    localparam int CAP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       pr = 1'b0;

    logic       rdy0, val0, full0, emp0, af0, ae0, ovf0, unf0;
    logic       rdy1, val1, full1, emp1, af1, ae1, ovf1, unf1;
    logic [7:0] d0, d1;
    logic [2:0] lvl0, lvl1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_v2 #(
        .WIDTH         (8),
        .DEPTH         (5),
        .OUT_REG       (0),
        .AFULL_THRESH  (3),
        .AEMPTY_THRESH (1)
    ) dut0 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_push_valid   (pv),
        .i_push_data    (pd),
        .o_push_ready   (rdy0),
        .o_pop_valid    (val0),
        .o_pop_data     (d0),
        .i_pop_ready    (pr),
        .o_full         (full0),
        .o_empty        (emp0),
        .o_almost_full  (af0),
        .o_almost_empty (ae0),
        .o_level        (lvl0),
        .o_overflow     (ovf0),
        .o_underflow    (unf0)
    );

    sync_fifo_v2 #(
        .WIDTH         (8),
        .DEPTH         (4),
        .OUT_REG       (1),
        .AFULL_THRESH  (3),
        .AEMPTY_THRESH (1)
    ) dut1 (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_push_valid   (pv),
        .i_push_data    (pd),
        .o_push_ready   (rdy1),
        .o_pop_valid    (val1),
        .o_pop_data     (d1),
        .i_pop_ready    (pr),
        .o_full         (full1),
        .o_empty        (emp1),
        .o_almost_full  (af1),
        .o_almost_empty (ae1),
        .o_level        (lvl1),
        .o_overflow     (ovf1),
        .o_underflow    (unf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock edge of the FIFO rules, applied to the queue model.
    task automatic model_edge(input bit v, input logic [7:0] d, input bit r, input bit f);
        int sz;
        sz = mq.size();
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (v && sz == CAP) m_ovf = 1'b1;
            if (r && sz == 0) m_unf = 1'b1;
            if (r && sz > 0) void'(mq.pop_front());
            if (v && sz < CAP) mq.push_back(d);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_dut(input string t, input logic rdy, input logic val,
                             input logic [7:0] d, input logic full, input logic emp,
                             input logic af, input logic ae, input logic [2:0] lvl,
                             input logic ovf, input logic unf);
        int sz;
        sz = mq.size();
        check({t, ".level"}, 32'(lvl), 32'(sz));
        check({t, ".push_ready"}, 32'(rdy), 32'(sz < CAP));
        check({t, ".pop_valid"}, 32'(val), 32'(sz > 0));
        check({t, ".full"}, 32'(full), 32'(sz == CAP));
        check({t, ".empty"}, 32'(emp), 32'(sz == 0));
        check({t, ".almost_full"}, 32'(af), 32'(sz >= 3));
        check({t, ".almost_empty"}, 32'(ae), 32'(sz <= 1));
        check({t, ".overflow"}, 32'(ovf), 32'(m_ovf));
        check({t, ".underflow"}, 32'(unf), 32'(m_unf));
        if (sz > 0) check({t, ".pop_data"}, 32'(d), 32'(mq[0]));
    endtask

    task automatic compare_all();
        check_dut("dut0", rdy0, val0, d0, full0, emp0, af0, ae0, lvl0, ovf0, unf0);
        check_dut("dut1", rdy1, val1, d1, full1, emp1, af1, ae1, lvl1, ovf1, unf1);
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit f);
        pv = v;
        pd = d;
        pr = r;
        flush = f;
        @(posedge clk);
        model_edge(v, d, r, f);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string t);
        check({t, ".d0_level"}, 32'(lvl0), 0);
        check({t, ".d1_level"}, 32'(lvl1), 0);
        check({t, ".d0_pop_valid"}, 32'(val0), 0);
        check({t, ".d1_pop_valid"}, 32'(val1), 0);
        check({t, ".d0_push_ready"}, 32'(rdy0), 1);
        check({t, ".d1_push_ready"}, 32'(rdy1), 1);
        check({t, ".d0_empty"}, 32'(emp0), 1);
        check({t, ".d1_full"}, 32'(full1), 0);
        check({t, ".d0_almost_empty"}, 32'(ae0), 1);
        check({t, ".d1_almost_full"}, 32'(af1), 0);
        check({t, ".d0_overflow"}, 32'(ovf0), 0);
        check({t, ".d1_underflow"}, 32'(unf1), 0);
        check({t, ".d1_pop_data"}, 32'(d1), 0);
    endtask

    initial begin
        int k;
        int max_lvl;

        #3;
        check_reset_values("rst_held");
        #5 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("rst_released");

        // Fill to capacity, then overflow.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        check("fill.level", 32'(lvl0), 5);
        check("fill.full", 32'(full0), 1);
        check("fill.full_reg", 32'(full1), 1);
        step(1'b1, 8'h16, 1'b0, 1'b0);
        check("ovf.set", 32'(ovf0), 1);
        check("ovf.set_reg", 32'(ovf1), 1);
        check("ovf.level", 32'(lvl1), 5);
        for (int i = 0; i < 5; i++) begin
            check("drain.d0", 32'(d0), 32'(8'h11 + 8'(i)));
            check("drain.d1", 32'(d1), 32'(8'h11 + 8'(i)));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain.empty", 32'(emp0), 1);
        check("drain.ovf_sticky", 32'(ovf0), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush.ovf_clear", 32'(ovf1), 0);

        // 12 pushes / 12 pops crossing the pointer wrap twice.
        k = 0;
        max_lvl = 0;
        step(1'b1, 8'h40, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0, 1'b0);
        for (int i = 2; i < 14; i++) begin
            if (int'(lvl0) > max_lvl) max_lvl = int'(lvl0);
            check("wrap.d0", 32'(d0), 32'(8'h40 + 8'(k)));
            check("wrap.d1", 32'(d1), 32'(8'h40 + 8'(k)));
            k++;
            step(i < 12, 8'h40 + 8'(i), 1'b1, 1'b0);
        end
        check("wrap.max_level_le_cap", 32'(max_lvl <= CAP), 1);
        check("wrap.empty", 32'(emp1), 1);

        // Push-to-valid latency, then fill to capacity.
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("lat.valid0", 32'(val0), 1);
        check("lat.valid1", 32'(val1), 1);
        check("lat.data0", 32'(d0), 32'h A5);
        check("lat.data1", 32'(d1), 32'h A5);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        check("lat.full_reg", 32'(full1), 1);
        check("lat.level_reg", 32'(lvl1), 5);

        // Down to level 2, then 20 cycles of simultaneous push and pop.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("stream.d0", 32'(d0), (i < 2) ? 32'(8'hB2 + 8'(i)) : 32'(8'h30 + 8'(i - 2)));
            check("stream.d1", 32'(d1), (i < 2) ? 32'(8'hB2 + 8'(i)) : 32'(8'h30 + 8'(i - 2)));
            step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
        end
        check("stream.level0", 32'(lvl0), 2);
        check("stream.level1", 32'(lvl1), 2);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow, thresholds, flush with a same-cycle push.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf.set", 32'(unf0), 1);
        step(1'b1, 8'h50, 1'b0, 1'b0);
        check("thr.ae_l1", 32'(ae1), 1);
        step(1'b1, 8'h51, 1'b0, 1'b0);
        check("thr.ae_l2", 32'(ae0), 0);
        check("thr.af_l2", 32'(af0), 0);
        step(1'b1, 8'h52, 1'b0, 1'b0);
        check("thr.af_l3", 32'(af1), 1);
        step(1'b1, 8'h60, 1'b0, 1'b1);
        check("fl.level", 32'(lvl0), 0);
        check("fl.empty", 32'(emp1), 1);
        check("fl.unf", 32'(unf1), 0);
        check("fl.ovf", 32'(ovf0), 0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("fl.next_head0", 32'(d0), 32'h77);
        check("fl.next_head1", 32'(d1), 32'h77);
        step(1'b1, 8'h78, 1'b0, 1'b0);
        step(1'b1, 8'h79, 1'b0, 1'b0);
        check("pre_rst.level", 32'(lvl1), 3);

        // Asynchronous reset pulse between clock edges.
        pv = 1'b0;
        pr = 1'b0;
        flush = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("rst_async");
        #1 rst_n = 1'b1;
        @(negedge clk);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
